// File: rtl/tile_pkg.sv
// Shared tile definitions: geometry constants, side and dispatch-writer state enums.
package tile_pkg;

    localparam int NV_PER_TILE  = 128;
    localparam int LINES_PER_NV = 4;
    localparam int NV_IDX_W     = 7;

    typedef enum logic {SIDE_LEFT, SIDE_RIGHT} tile_side_e;

    typedef enum logic [1:0] {DW_IDLE, DW_WRITE, DW_DONE} dw_state_e;

    // First tile line of an NV: each NV occupies LINES_PER_NV consecutive lines.
    function automatic logic [NV_IDX_W+1:0] nv_line_base(input logic [NV_IDX_W-1:0] nv);
        return {nv, 2'b00};
    endfunction

endpackage

// File: rtl/tile_dispatch_writer_if.sv
// Command + mantissa-line stream into the tile dispatch writer.
// master = L2 dispatch side, slave = tile_dispatch_writer.
interface tile_dispatch_writer_if #(
    parameter int MAN_WIDTH = 256,
    parameter int EXP_WIDTH = 8
);
    import tile_pkg::*;

    logic                    i_cmd_valid;
    logic                    o_cmd_ready;
    tile_side_e              i_cmd_side;
    logic [NV_IDX_W-1:0]     i_cmd_start_nv;
    logic [7:0]              i_cmd_num_nv;

    logic                    i_line_valid;
    logic                    o_line_ready;
    logic [MAN_WIDTH-1:0]    i_line_man;
    logic [EXP_WIDTH-1:0]    i_line_exp;

    modport master (
        output i_cmd_valid, i_cmd_side, i_cmd_start_nv, i_cmd_num_nv,
        output i_line_valid, i_line_man, i_line_exp,
        input  o_cmd_ready, o_line_ready
    );

    modport slave (
        input  i_cmd_valid, i_cmd_side, i_cmd_start_nv, i_cmd_num_nv,
        input  i_line_valid, i_line_man, i_line_exp,
        output o_cmd_ready, o_line_ready
    );

endinterface

// File: rtl/tile_dispatch_writer.sv
// Tile write-side driver: turns one dispatch command plus its line stream into
// line-addressed writes on the tile mantissa/exponent write ports.
// Optional macro TILE_DISPATCH_ERR_EN adds a sticky o_err and rejects
// commands that run past the last NV of the tile.
module tile_dispatch_writer
    import tile_pkg::*;
#(
    parameter int MAN_WIDTH  = 256,
    parameter int EXP_WIDTH  = 8,
    parameter int BRAM_DEPTH = 512,
    parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    tile_dispatch_writer_if.slave bus,

    output logic [ADDR_WIDTH-1:0] o_man_left_wr_addr,
    output logic                  o_man_left_wr_en,
    output logic [MAN_WIDTH-1:0]  o_man_left_wr_data,
    output logic [ADDR_WIDTH-1:0] o_man_right_wr_addr,
    output logic                  o_man_right_wr_en,
    output logic [MAN_WIDTH-1:0]  o_man_right_wr_data,
    output logic [ADDR_WIDTH-1:0] o_exp_left_wr_addr,
    output logic                  o_exp_left_wr_en,
    output logic [EXP_WIDTH-1:0]  o_exp_left_wr_data,
    output logic [ADDR_WIDTH-1:0] o_exp_right_wr_addr,
    output logic                  o_exp_right_wr_en,
    output logic [EXP_WIDTH-1:0]  o_exp_right_wr_data,

    output logic                  o_busy,
    output logic                  o_done,
`ifdef TILE_DISPATCH_ERR_EN
    output logic                  o_err,
`endif
    output logic [ADDR_WIDTH:0]   o_lines_written
);

    // Line count of a command: 8-bit NV count times four lines per NV.
    localparam int CNT_W = 10;
    localparam int LW_W  = ADDR_WIDTH + 1;

    dw_state_e               state;
    tile_side_e              side_q;
    logic [NV_IDX_W-1:0]     start_nv_q;
    logic [CNT_W-1:0]        total_q;
    logic [CNT_W-1:0]        count_q;
    logic                    cmd_ready_q;

    logic                    cmd_acc;
    logic                    beat_acc;
    logic                    cmd_bad;
    logic [ADDR_WIDTH-1:0]   line_addr;

    assign cmd_acc  = bus.i_cmd_valid && cmd_ready_q;
    // In WRITE the count is always below total: the last beat leaves WRITE.
    assign beat_acc = bus.i_line_valid && (state == DW_WRITE);

    assign bus.o_cmd_ready  = cmd_ready_q;
    assign bus.o_line_ready = (state == DW_WRITE);

    // Address wraps naturally at the tile depth.
    assign line_addr = ADDR_WIDTH'(nv_line_base(start_nv_q)) + ADDR_WIDTH'(count_q);

`ifdef TILE_DISPATCH_ERR_EN
    assign cmd_bad = (({2'b00, bus.i_cmd_start_nv} + {1'b0, bus.i_cmd_num_nv}) > 9'(NV_PER_TILE))
                  || (bus.i_cmd_num_nv > 8'(NV_PER_TILE));
`else
    assign cmd_bad = 1'b0;
`endif

    // Dispatch FSM with registered write strobes, status and handshake ready.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state               <= DW_IDLE;
            side_q              <= SIDE_LEFT;
            start_nv_q          <= '0;
            total_q             <= '0;
            count_q             <= '0;
            cmd_ready_q         <= 1'b1;
            o_busy              <= 1'b0;
            o_done              <= 1'b0;
            o_lines_written     <= '0;
            o_man_left_wr_en    <= 1'b0;
            o_man_right_wr_en   <= 1'b0;
            o_exp_left_wr_en    <= 1'b0;
            o_exp_right_wr_en   <= 1'b0;
            o_man_left_wr_addr  <= '0;
            o_man_right_wr_addr <= '0;
            o_exp_left_wr_addr  <= '0;
            o_exp_right_wr_addr <= '0;
            o_man_left_wr_data  <= '0;
            o_man_right_wr_data <= '0;
            o_exp_left_wr_data  <= '0;
            o_exp_right_wr_data <= '0;
`ifdef TILE_DISPATCH_ERR_EN
            o_err               <= 1'b0;
`endif
        end else begin
            o_man_left_wr_en  <= 1'b0;
            o_man_right_wr_en <= 1'b0;
            o_exp_left_wr_en  <= 1'b0;
            o_exp_right_wr_en <= 1'b0;
            o_done            <= 1'b0;

            case (state)
                DW_IDLE: begin
                    if (cmd_acc) begin
                        side_q          <= bus.i_cmd_side;
                        start_nv_q      <= bus.i_cmd_start_nv;
                        total_q         <= {bus.i_cmd_num_nv, 2'b00};
                        count_q         <= '0;
                        o_lines_written <= '0;
                        cmd_ready_q     <= 1'b0;
                        o_busy          <= 1'b1;
                        if (bus.i_cmd_num_nv == 8'd0 || cmd_bad)
                            state <= DW_DONE;
                        else
                            state <= DW_WRITE;
`ifdef TILE_DISPATCH_ERR_EN
                        if (cmd_bad)
                            o_err <= 1'b1;
`endif
                    end else if (!cmd_ready_q) begin
                        // Reopen for commands only after the done pulse cycle.
                        cmd_ready_q <= 1'b1;
                    end
                end

                DW_WRITE: begin
                    if (beat_acc) begin
                        count_q         <= count_q + CNT_W'(1);
                        o_lines_written <= o_lines_written + LW_W'(1);
                        if (side_q == SIDE_LEFT) begin
                            o_man_left_wr_en   <= 1'b1;
                            o_exp_left_wr_en   <= 1'b1;
                            o_man_left_wr_addr <= line_addr;
                            o_exp_left_wr_addr <= line_addr;
                            o_man_left_wr_data <= bus.i_line_man;
                            o_exp_left_wr_data <= bus.i_line_exp;
                        end else begin
                            o_man_right_wr_en   <= 1'b1;
                            o_exp_right_wr_en   <= 1'b1;
                            o_man_right_wr_addr <= line_addr;
                            o_exp_right_wr_addr <= line_addr;
                            o_man_right_wr_data <= bus.i_line_man;
                            o_exp_right_wr_data <= bus.i_line_exp;
                        end
                        if (count_q == total_q - CNT_W'(1))
                            state <= DW_DONE;
                    end
                end

                DW_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= DW_IDLE;
                end

                default: state <= DW_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_dispatch_writer.sv
// Randomized directed bench for tile_dispatch_writer against a cycle-level
// transaction model (expected writes, done/ready timing, line counts).
module tb_tile_dispatch_writer;
    import tile_pkg::*;

    localparam int MW    = 256;
    localparam int EW    = 8;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int BIG   = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_dispatch_writer_if #(.MAN_WIDTH(MW), .EXP_WIDTH(EW)) bus();

    logic [AW-1:0] man_l_addr, man_r_addr, exp_l_addr, exp_r_addr;
    logic          man_l_en, man_r_en, exp_l_en, exp_r_en;
    logic [MW-1:0] man_l_data, man_r_data;
    logic [EW-1:0] exp_l_data, exp_r_data;
    logic          busy, done;
    logic [AW:0]   lines_written;
`ifdef TILE_DISPATCH_ERR_EN
    logic          err;
`endif

    tile_dispatch_writer #(.MAN_WIDTH(MW), .EXP_WIDTH(EW), .BRAM_DEPTH(DEPTH)) dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .bus                 (bus.slave),
        .o_man_left_wr_addr  (man_l_addr),
        .o_man_left_wr_en    (man_l_en),
        .o_man_left_wr_data  (man_l_data),
        .o_man_right_wr_addr (man_r_addr),
        .o_man_right_wr_en   (man_r_en),
        .o_man_right_wr_data (man_r_data),
        .o_exp_left_wr_addr  (exp_l_addr),
        .o_exp_left_wr_en    (exp_l_en),
        .o_exp_left_wr_data  (exp_l_data),
        .o_exp_right_wr_addr (exp_r_addr),
        .o_exp_right_wr_en   (exp_r_en),
        .o_exp_right_wr_data (exp_r_data),
        .o_busy              (busy),
        .o_done              (done),
`ifdef TILE_DISPATCH_ERR_EN
        .o_err               (err),
`endif
        .o_lines_written     (lines_written)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction model state
    int  m_rem = 0, m_idx = 0, m_base = 0;
    int  m_done_at = -1, m_ready_at = 0, m_acc_cnt = 0, e_lw = 0;
    int  acc_cyc = 0, last_done_cyc = -100;
    bit  m_side = 0, m_err = 0;
    bit  e_l_en, e_r_en;
    logic [AW-1:0] e_l_addr, e_r_addr;
    logic [MW-1:0] e_l_man, e_r_man;
    logic [EW-1:0] e_l_exp, e_r_exp;

    function automatic logic [MW-1:0] rnd_man();
        logic [MW-1:0] r;
        for (int i = 0; i < MW/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic bit m_cmd_rdy();
        return (m_rem == 0) && (cyc >= m_ready_at);
    endfunction

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: update the model from this cycle's handshakes, then check outputs.
    task automatic tick();
        bit cacc, bacc, bad;
        int st, num, a;
        cacc = !rst && bus.i_cmd_valid && m_cmd_rdy();
        bacc = !rst && bus.i_line_valid && (m_rem > 0);
        e_l_en = 0;
        e_r_en = 0;
        if (rst) begin
            m_rem = 0; m_idx = 0; m_done_at = -1; m_ready_at = 0; e_lw = 0; m_err = 0;
            e_l_addr = '0; e_r_addr = '0; e_l_man = '0; e_r_man = '0; e_l_exp = '0; e_r_exp = '0;
        end else begin
            if (cacc) begin
                st     = int'(bus.i_cmd_start_nv);
                num    = int'(bus.i_cmd_num_nv);
                m_side = (bus.i_cmd_side == SIDE_RIGHT);
                m_base = st * 4;
                m_idx  = 0;
                e_lw   = 0;
                acc_cyc = cyc;
                m_acc_cnt++;
                bad = 0;
`ifdef TILE_DISPATCH_ERR_EN
                bad = (st + num > 128);
                if (bad) m_err = 1;
`endif
                if (num == 0 || bad) begin
                    m_rem = 0; m_done_at = cyc + 2; m_ready_at = cyc + 3;
                end else begin
                    m_rem = num * 4; m_ready_at = BIG;
                end
            end
            if (bacc) begin
                a = (m_base + m_idx) % DEPTH;
                if (m_side) begin
                    e_r_en = 1; e_r_addr = AW'(a); e_r_man = bus.i_line_man; e_r_exp = bus.i_line_exp;
                end else begin
                    e_l_en = 1; e_l_addr = AW'(a); e_l_man = bus.i_line_man; e_l_exp = bus.i_line_exp;
                end
                m_idx++;
                m_rem--;
                e_lw++;
                if (m_rem == 0) begin
                    m_done_at = cyc + 2; m_ready_at = cyc + 3;
                end
            end
        end

        @(posedge clk);
        cyc++;
        #1;
        if (done === 1'b1) last_done_cyc = cyc;

        chk("cmd_ready",     MW'(bus.o_cmd_ready),  MW'(m_cmd_rdy()));
        chk("line_ready",    MW'(bus.o_line_ready), MW'(m_rem > 0));
        chk("done",          MW'(done),             MW'(cyc == m_done_at));
        chk("lines_written", MW'(lines_written),    MW'(e_lw));
        chk("man_l_en",      MW'(man_l_en),         MW'(e_l_en));
        chk("exp_l_en",      MW'(exp_l_en),         MW'(e_l_en));
        chk("man_r_en",      MW'(man_r_en),         MW'(e_r_en));
        chk("exp_r_en",      MW'(exp_r_en),         MW'(e_r_en));
        chk("man_l_addr",    MW'(man_l_addr),       MW'(e_l_addr));
        chk("exp_l_addr",    MW'(exp_l_addr),       MW'(e_l_addr));
        chk("man_r_addr",    MW'(man_r_addr),       MW'(e_r_addr));
        chk("exp_r_addr",    MW'(exp_r_addr),       MW'(e_r_addr));
        chk("man_l_data",    man_l_data,            e_l_man);
        chk("man_r_data",    man_r_data,            e_r_man);
        chk("exp_l_data",    MW'(exp_l_data),       MW'(e_l_exp));
        chk("exp_r_data",    MW'(exp_r_data),       MW'(e_r_exp));
        if (m_rem > 0)        chk("busy_active", MW'(busy), MW'(1));
        else if (m_cmd_rdy()) chk("busy_idle",   MW'(busy), MW'(0));
`ifdef TILE_DISPATCH_ERR_EN
        chk("err",           MW'(err),              MW'(m_err));
`endif
        bus.i_line_man = rnd_man();
        bus.i_line_exp = EW'($urandom());
    endtask

    task automatic timeout(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: bound expired at cycle %0d, want event", tag, cyc);
    endtask

    task automatic send_cmd(input bit side, input int st, input int num);
        int n0 = m_acc_cnt;
        int k  = 0;
        bus.i_cmd_side     = side ? SIDE_RIGHT : SIDE_LEFT;
        bus.i_cmd_start_nv = st[6:0];
        bus.i_cmd_num_nv   = num[7:0];
        bus.i_cmd_valid    = 1'b1;
        while (m_acc_cnt == n0 && k < 200) begin tick(); k++; end
        if (m_acc_cnt == n0) timeout("cmd_accept");
        bus.i_cmd_valid = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid.
    task automatic feed(input int mode, input int stop_after);
        int k = 0;
        while (m_rem > 0 && !(stop_after >= 0 && m_idx >= stop_after) && k < 3000) begin
            case (mode)
                0:       bus.i_line_valid = 1'b1;
                1:       bus.i_line_valid = (k % 2 == 0);
                default: bus.i_line_valid = 1'($urandom());
            endcase
            tick();
            k++;
        end
        bus.i_line_valid = 1'b0;
        if (m_rem > 0 && stop_after < 0) timeout("beat_stream");
    endtask

    // Stray beats are offered while waiting; none may be accepted.
    task automatic wait_idle();
        int k = 0;
        while (!m_cmd_rdy() && k < 50) begin
            bus.i_line_valid = 1'($urandom());
            tick();
            k++;
        end
        bus.i_line_valid = 1'b0;
        if (!m_cmd_rdy()) timeout("idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, k;
        rst                = 1'b1;
        bus.i_cmd_valid    = 1'b0;
        bus.i_cmd_side     = SIDE_LEFT;
        bus.i_cmd_start_nv = '0;
        bus.i_cmd_num_nv   = '0;
        bus.i_line_valid   = 1'b0;
        bus.i_line_man     = '0;
        bus.i_line_exp     = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single NV, left, back-to-back beats
        send_cmd(0, 0, 1);
        feed(0, -1);
        wait_idle();

        // Two NVs, right, valid toggling
        send_cmd(1, 10, 2);
        feed(1, -1);
        wait_idle();

        // Empty command
        bus.i_line_valid = 1'b1;
        send_cmd(0, 7, 0);
        wait_idle();

        // Reset after 3 of 8 beats, then a fresh command from NV 5
        send_cmd(0, 3, 2);
        feed(0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        send_cmd(0, 5, 1);
        feed(0, -1);
        wait_idle();

        // Wrap past the last NV (error path when the check is compiled in)
        send_cmd(1, 127, 2);
        feed(0, -1);
        wait_idle();

        // Second command held valid while the first is still in flight
        send_cmd(0, 20, 1);
        bus.i_cmd_side     = SIDE_RIGHT;
        bus.i_cmd_start_nv = 7'd21;
        bus.i_cmd_num_nv   = 8'd1;
        bus.i_cmd_valid    = 1'b1;
        feed(0, -1);
        n0 = m_acc_cnt;
        k  = 0;
        while (m_acc_cnt == n0 && k < 50) begin tick(); k++; end
        bus.i_cmd_valid = 1'b0;
        if (m_acc_cnt == n0) timeout("b2b_accept");
        else chk("b2b_gap", MW'(acc_cyc - last_done_cyc), MW'(1));
        feed(2, -1);
        wait_idle();

        // Randomized commands
        for (int i = 0; i < 10; i++) begin
            send_cmd(1'($urandom()), int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
            feed(int'($urandom_range(0, 2)), -1);
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
